serial_sub: RTL and testbench

//  Bit-serial WIDTH-bit unsigned subtractor: diff = a - b, borr = borrow out.

---
 rtl/serial_sub.sv | 115 +++++++++++
 tb/tb_serial_sub.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, diff = a - b, borr = (a < b).
// Latency: result registered WIDTH edges after the accepting edge; WIDTH+2 cycles per op minimum.
// Backpressure: one op in flight; in_ready low until the result is taken via out_valid/out_ready.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             borrow;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;

  // one-bit subtract cell on the current LSBs
  logic             x;
  logic             y;
  logic             c;
  logic             d;
  logic             borrow_nx;
  logic [WIDTH-1:0] diff_nx;

  // Full-subtractor cell; new difference bit enters the result at the MSB
  always_comb begin
    x         = a_sh[0];
    y         = b_sh[0];
    c         = borrow;
    d         = x ^ y ^ c;
    borrow_nx = (~x & y) | (~(x ^ y) & c);
    diff_nx   = diff_sh >> 1;
    diff_nx[WIDTH-1] = d;
  end

  // Control FSM with datapath shift registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      borrow    <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      diff_sh   <= '0;
      diff      <= '0;
      borr      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow   <= 1'b0;
            count    <= '0;
            diff_sh  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          borrow  <= borrow_nx;
          diff_sh <= diff_nx;
          count   <= count + CW'(1);
          // last bit: publish the completed word and final borrow together
          if (count == LAST) begin
            diff      <= diff_nx;
            borr      <= borrow_nx;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: exercises an 8-bit and a 1-bit serial_sub against an
// arithmetic reference (a - b mod 2^W, a < b) with directed and random ops.
// Both instances share clock and reset.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // 8-bit instance
  logic       iv8 = 1'b0;
  logic       ir8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ov8;
  logic       or8 = 1'b0;
  logic [7:0] d8;
  logic       bo8;
  logic       bz8;

  // 1-bit instance
  logic       iv1 = 1'b0;
  logic       ir1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       ov1;
  logic       or1 = 1'b0;
  logic [0:0] d1;
  logic       bo1;
  logic       bz1;

  int checks = 0;
  int failures = 0;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borr(bo8), .busy(bz8)
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .borr(bo1), .busy(bz1)
  );

  // reference model
  function automatic int ref_diff(input int aa, input int bb, input int w);
    int mask;
    mask = (1 << w) - 1;
    return (aa - bb) & mask;
  endfunction

  function automatic bit ref_borr(input int aa, input int bb);
    return aa < bb;
  endfunction

  // stimulus helpers: issue one op, report edges from accept to out_valid (-1 on timeout)
  task automatic run8(input logic [7:0] aa, input logic [7:0] bb, output int lat);
    int n;
    n = 0;
    while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
    if (!ir8) begin lat = -1; return; end
    a8 = aa; b8 = bb; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!ov8) lat = -1;
  endtask

  task automatic run1(input logic [0:0] aa, input logic [0:0] bb, output int lat);
    int n;
    n = 0;
    while (!ir1 && n < 50) begin @(posedge clk); #1; n++; end
    if (!ir1) begin lat = -1; return; end
    a1 = aa; b1 = bb; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    lat = 0;
    while (!ov1 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!ov1) lat = -1;
  endtask

  task automatic release8();
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic release1();
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ir8, ov8, bz8, bo8, d8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset8 got rdy=%0b vld=%0b busy=%0b borr=%0b diff=%h want 1 0 0 0 00",
               ir8, ov8, bz8, bo8, d8);
    end
    checks++;
    if ({ir1, ov1, bz1, bo1, d1} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset1 got rdy=%0b vld=%0b busy=%0b borr=%0b diff=%0b want 1 0 0 0 0",
               ir1, ov1, bz1, bo1, d1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_width1();
    int lat;
    int ed;
    bit eb;
    for (int i = 0; i < 4; i++) begin
      logic [0:0] aa;
      logic [0:0] bb;
      aa = 1'(i >> 1);
      bb = 1'(i & 1);
      ed = ref_diff(int'(aa), int'(bb), 1);
      eb = ref_borr(int'(aa), int'(bb));
      run1(aa, bb, lat);
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL w1_latency a=%0d b=%0d got %0d want 1", aa, bb, lat);
      end
      checks++;
      if ({d1, bo1} !== {ed[0], eb}) begin
        failures++;
        $display("FAIL w1_result a=%0d b=%0d got diff=%0b borr=%0b want %0b %0b",
                 aa, bb, d1, bo1, ed[0], eb);
      end
      release1();
    end
  endtask

  task automatic test_basic();
    int lat;
    run8(8'h5A, 8'h23, lat);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL basic_latency got %0d edges after accept want 8", lat);
    end
    checks++;
    if ({d8, bo8} !== {8'h37, 1'b0}) begin
      failures++;
      $display("FAIL basic_result got diff=%h borr=%0b want 37 0", d8, bo8);
    end
    checks++;
    if ({ir8, bz8} !== 2'b01) begin
      failures++;
      $display("FAIL basic_done_flags got rdy=%0b busy=%0b want 0 1", ir8, bz8);
    end
    release8();
    checks++;
    if ({ov8, ir8, bz8, d8} !== {1'b0, 1'b1, 1'b0, 8'h37}) begin
      failures++;
      $display("FAIL basic_after_hs got vld=%0b rdy=%0b busy=%0b diff=%h want 0 1 0 37",
               ov8, ir8, bz8, d8);
    end
  endtask

  task automatic test_borrow_cases();
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    int lat;
    int ed;
    bit eb;
    ta[0] = 8'h10; tb[0] = 8'h20;
    ta[1] = 8'h00; tb[1] = 8'h01;
    ta[2] = 8'hFF; tb[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      ed = ref_diff(int'(ta[i]), int'(tb[i]), 8);
      eb = ref_borr(int'(ta[i]), int'(tb[i]));
      run8(ta[i], tb[i], lat);
      checks++;
      if ({d8, bo8} !== {ed[7:0], eb} || lat !== 8) begin
        failures++;
        $display("FAIL borrow_case a=%h b=%h got diff=%h borr=%0b lat=%0d want %h %0b 8",
                 ta[i], tb[i], d8, bo8, lat, ed[7:0], eb);
      end
      release8();
    end
  endtask

  task automatic test_hold();
    int lat;
    run8(8'h5A, 8'h23, lat);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin a8 = 8'h01; b8 = 8'h01; iv8 = 1'b1; end
      if (i == 6) iv8 = 1'b0;
      checks++;
      if ({ov8, d8, bo8, ir8} !== {1'b1, 8'h37, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold cycle=%0d got vld=%0b diff=%h borr=%0b rdy=%0b want 1 37 0 0",
                 i, ov8, d8, bo8, ir8);
      end
      @(posedge clk); #1;
    end
    release8();
    checks++;
    if ({ov8, ir8, bz8} !== 3'b010) begin
      failures++;
      $display("FAIL hold_release got vld=%0b rdy=%0b busy=%0b want 0 1 0", ov8, ir8, bz8);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ov8, bz8, d8} !== {1'b0, 1'b0, 8'h37}) begin
      failures++;
      $display("FAIL hold_no_queue got vld=%0b busy=%0b diff=%h want 0 0 37", ov8, bz8, d8);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    checks++;
    if (ir8 !== 1'b1) begin
      failures++;
      $display("FAIL midrst_idle got rdy=%0b want 1", ir8);
    end
    a8 = 8'h80; b8 = 8'h01; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ov8, d8, bz8, bo8} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_state got vld=%0b diff=%h busy=%0b borr=%0b want 0 00 0 0",
               ov8, d8, bz8, bo8);
    end
    rst_n = 1'b1;
    run8(8'h03, 8'h05, lat);
    checks++;
    if ({d8, bo8} !== {8'hFE, 1'b1} || lat !== 8) begin
      failures++;
      $display("FAIL midrst_next got diff=%h borr=%0b lat=%0d want FE 1 8", d8, bo8, lat);
    end
    release8();
  endtask

  task automatic test_back_to_back();
    int qa[$];
    int qb[$];
    int qacc[$];
    int cyc;
    int n_acc;
    int n_done;
    int last_acc;
    int acc_now;
    int ea;
    int eb;
    int ec;
    int ed;
    bit ebr;
    cyc = 0; n_acc = 0; n_done = 0; last_acc = -1;
    or8 = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
    while (n_done < 1000 && cyc < 13000) begin
      acc_now = 0;
      if (iv8 && ir8 && n_acc < 1000) begin
        acc_now = 1;
        if (last_acc >= 0) begin
          checks++;
          if ((cyc + 1) - last_acc !== 10) begin
            failures++;
            $display("FAIL b2b_spacing op=%0d got %0d cycles want 10", n_acc, (cyc + 1) - last_acc);
          end
        end
        last_acc = cyc + 1;
        qa.push_back(int'(a8));
        qb.push_back(int'(b8));
        qacc.push_back(cyc + 1);
        n_acc++;
      end
      if (ov8) begin
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b2b_spurious got out_valid=1 with no op pending want 0");
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          ec = qacc.pop_front();
          ed = ref_diff(ea, eb, 8);
          ebr = ref_borr(ea, eb);
          checks++;
          if ({d8, bo8} !== {ed[7:0], ebr}) begin
            failures++;
            $display("FAIL b2b_result a=%h b=%h got diff=%h borr=%0b want %h %0b",
                     ea[7:0], eb[7:0], d8, bo8, ed[7:0], ebr);
          end
          checks++;
          if (cyc - ec !== 8) begin
            failures++;
            $display("FAIL b2b_latency a=%h b=%h got %0d want 8", ea[7:0], eb[7:0], cyc - ec);
          end
          n_done++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now != 0) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        if (n_acc >= 1000) iv8 = 1'b0;
      end
    end
    iv8 = 1'b0;
    or8 = 1'b0;
    checks++;
    if (n_done !== 1000) begin
      failures++;
      $display("FAIL b2b_count got %0d completed ops want 1000", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_width1();
    test_basic();
    test_borrow_cases();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
